// File: rtl/apb_bridge_pkg.sv
// Shared definitions for upstream APB bridges: transfer state encoding and
// watchdog counter sizing.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Counter wide enough to hold LIMIT itself; a disabled watchdog still gets 1 bit.
  function automatic int unsigned wdog_width(input int unsigned limit);
    if (limit == 0) begin
      return 1;
    end
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_bridge_watchdog.sv
// Saturating ACCESS-phase watchdog: counts enabled cycles and flags expiry at LIMIT.
// LIMIT = 0 removes the counter entirely and never expires.
module apb_watchdog_cnt
  import apb_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = wdog_width(LIMIT);

  generate
    if (LIMIT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk_i, rst_ni, clear_i, en_i};
      assign expired_o     = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LIM = CW'(LIMIT);

      logic [CW-1:0] cnt_q, cnt_d;

      // Stops at LIM so the count can never wrap back below the abort point.
      always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != LIM)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired_o = (cnt_q == LIM);
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// PULP req/gnt + r_valid port to single-transfer APB3 master, with an ACCESS
// watchdog that turns a missing PREADY into an error response.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // request port
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [APB_DATA_WIDTH-1:0] r_rdata_o,
  output logic                      r_err_o,
  // APB master port
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_o,
  output logic                      PWRITE_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i
);

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      rvalid_q, rvalid_d;

  logic wdog_clear;
  logic wdog_en;
  logic wdog_expired;

  assign wdog_clear = (state_q != ACCESS);
  assign wdog_en    = (state_q == ACCESS) && !PREADY_i;

  apb_watchdog_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (wdog_clear),
    .en_i      (wdog_en),
    .expired_o (wdog_expired)
  );

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d  = SETUP;
          paddr_d  = addr_i;
          pwdata_d = wdata_i;
          pwrite_d = we_i;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority so a slave answering on the last allowed cycle completes normally.
        if (PREADY_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : PRDATA_i;
          err_d    = PSLVERR_i;
        end else if (wdog_expired) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt_o     = (state_q == IDLE) && req_i;
  assign PSEL_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE_o = (state_q == ACCESS);
  assign PADDR_o   = paddr_q;
  assign PWDATA_o  = pwdata_q;
  assign PWRITE_o  = pwrite_q;
  assign r_valid_o = rvalid_q;
  assign r_rdata_o = rdata_q;
  assign r_err_o   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (watchdog limit 4): one task per scenario.
module tb_apb_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        r_valid_o;
  logic [31:0] r_rdata_o;
  logic        r_err_o;
  logic [31:0] PADDR_o;
  logic [31:0] PWDATA_o;
  logic        PWRITE_o;
  logic        PSEL_o;
  logic        PENABLE_o;
  logic [31:0] PRDATA_i;
  logic        PREADY_i;
  logic        PSLVERR_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  apb_master_bridge #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .wdata_i   (wdata_i),
    .gnt_o     (gnt_o),
    .r_valid_o (r_valid_o),
    .r_rdata_o (r_rdata_o),
    .r_err_o   (r_err_o),
    .PADDR_o   (PADDR_o),
    .PWDATA_o  (PWDATA_o),
    .PWRITE_o  (PWRITE_o),
    .PSEL_o    (PSEL_o),
    .PENABLE_o (PENABLE_o),
    .PRDATA_i  (PRDATA_i),
    .PREADY_i  (PREADY_i),
    .PSLVERR_i (PSLVERR_i)
  );

  task automatic test_reset();
    #2;
    vectors++;
    if ({PSEL_o, PENABLE_o, PWRITE_o, r_valid_o, r_err_o, gnt_o} !== 6'b0 ||
        PADDR_o !== 32'h0 || PWDATA_o !== 32'h0 || r_rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: psel/pen/pwr/rv/err/gnt=%b paddr=%h pwdata=%h rdata=%h, want all 0",
               {PSEL_o, PENABLE_o, PWRITE_o, r_valid_o, r_err_o, gnt_o}, PADDR_o, PWDATA_o, r_rdata_o);
    end
    #20 rst_ni = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_read_zero_wait();
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_0004; we_i = 1'b0; wdata_i = 32'h0;
    PREADY_i = 1'b1; PSLVERR_i = 1'b0; PRDATA_i = 32'hCAFE_0001;
    #1;
    vectors++;
    if (gnt_o !== 1'b1 || PSEL_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_c0_grant: gnt=%b psel=%b want gnt=1 psel=0", gnt_o, PSEL_o);
    end
    @(posedge clk_i); #1; req_i = 1'b0; #1;
    vectors++;
    if ({PSEL_o, PENABLE_o, PWRITE_o, gnt_o} !== 4'b1000 || PADDR_o !== 32'h1A10_0004) begin
      miscompares++;
      $display("FAIL rd_c1_setup: psel/pen/pwr/gnt=%b paddr=%h want 1000 1a100004",
               {PSEL_o, PENABLE_o, PWRITE_o, gnt_o}, PADDR_o);
    end
    @(posedge clk_i); #2;
    vectors++;
    if ({PSEL_o, PENABLE_o, r_valid_o} !== 3'b110) begin
      miscompares++;
      $display("FAIL rd_c2_access: psel/pen/rv=%b want 110", {PSEL_o, PENABLE_o, r_valid_o});
    end
    @(posedge clk_i); #2;
    vectors++;
    if (r_valid_o !== 1'b1 || r_rdata_o !== 32'hCAFE_0001 || r_err_o !== 1'b0 ||
        PSEL_o !== 1'b0 || PENABLE_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_c3_resp: rv=%b rdata=%h err=%b psel=%b pen=%b want 1 cafe0001 0 0 0",
               r_valid_o, r_rdata_o, r_err_o, PSEL_o, PENABLE_o);
    end
    @(posedge clk_i); #2;
    vectors++;
    if (r_valid_o !== 1'b0 || r_rdata_o !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL rd_c4_hold: rv=%b rdata=%h want 0 cafe0001", r_valid_o, r_rdata_o);
    end
    $display("read  1a100004 zero-wait -> rdata=%h err=%b", r_rdata_o, r_err_o);
  endtask

  task automatic test_write_wait();
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_0008; we_i = 1'b1; wdata_i = 32'h0000_00A5;
    PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (gnt_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_c0_grant: gnt=%b want 1", gnt_o);
    end
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) req_i = 1'b0;
      if (c == 5) PREADY_i = 1'b1;
      #1;
      vectors++;
      if (PSEL_o !== 1'b1 || PENABLE_o !== (c >= 2) || PWRITE_o !== 1'b1 ||
          PADDR_o !== 32'h1A10_0008 || PWDATA_o !== 32'h0000_00A5 || r_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_c%0d_bus: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b want 1 %0d 1 1a100008 000000a5 0",
                 c, PSEL_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o, r_valid_o, (c >= 2));
      end
    end
    @(posedge clk_i); #2;
    vectors++;
    if (r_valid_o !== 1'b1 || r_rdata_o !== 32'h0 || r_err_o !== 1'b0 || PSEL_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_c6_resp: rv=%b rdata=%h err=%b psel=%b want 1 00000000 0 0",
               r_valid_o, r_rdata_o, r_err_o, PSEL_o);
    end
    $display("write 1a100008 <- 000000a5 3 waits -> err=%b", r_err_o);
    PREADY_i = 1'b1;
  endtask

  task automatic test_slverr();
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_000C; we_i = 1'b0;
    PREADY_i = 1'b1; PSLVERR_i = 1'b1; PRDATA_i = 32'h1234_5678;
    @(posedge clk_i); #1; req_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i); #2;
    vectors++;
    if (r_valid_o !== 1'b1 || r_err_o !== 1'b1 || r_rdata_o !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL slverr_resp: rv=%b err=%b rdata=%h want 1 1 12345678", r_valid_o, r_err_o, r_rdata_o);
    end
    $display("read  1a10000c pslverr -> rdata=%h err=%b", r_rdata_o, r_err_o);
    PSLVERR_i = 1'b0;
  endtask

  task automatic test_timeout();
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_00F0; we_i = 1'b0;
    PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = 32'h7777_7777;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) req_i = 1'b0;
      #1;
      vectors++;
      if (PSEL_o !== 1'b1 || PENABLE_o !== (c >= 2) || r_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL to_c%0d_wait: psel=%b pen=%b rv=%b want 1 %0d 0", c, PSEL_o, PENABLE_o, r_valid_o, (c >= 2));
      end
    end
    // c7: abort response, bus idle, and a new request is granted in the same cycle
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_00F4; we_i = 1'b0;
    #1;
    vectors++;
    if (r_valid_o !== 1'b1 || r_err_o !== 1'b1 || r_rdata_o !== 32'h0 ||
        PSEL_o !== 1'b0 || PENABLE_o !== 1'b0 || gnt_o !== 1'b1) begin
      miscompares++;
      $display("FAIL to_c7_abort: rv=%b err=%b rdata=%h psel=%b pen=%b gnt=%b want 1 1 00000000 0 0 1",
               r_valid_o, r_err_o, r_rdata_o, PSEL_o, PENABLE_o, gnt_o);
    end
    $display("read  1a1000f0 timeout -> rdata=%h err=%b", r_rdata_o, r_err_o);
    // PREADY arriving on the expiry cycle (grant c7, ACCESS c9..c13) completes normally
    for (int c = 8; c <= 13; c++) begin
      @(posedge clk_i); #1;
      if (c == 8) req_i = 1'b0;
      if (c == 13) begin
        PREADY_i = 1'b1; PRDATA_i = 32'h0BAD_F00D;
      end
      #1;
      vectors++;
      if (PSEL_o !== 1'b1 || PENABLE_o !== (c >= 9) || r_valid_o !== 1'b0 || PADDR_o !== 32'h1A10_00F4) begin
        miscompares++;
        $display("FAIL race_c%0d_wait: psel=%b pen=%b rv=%b paddr=%h want 1 %0d 0 1a1000f4",
                 c, PSEL_o, PENABLE_o, r_valid_o, PADDR_o, (c >= 9));
      end
    end
    @(posedge clk_i); #2;
    vectors++;
    if (r_valid_o !== 1'b1 || r_err_o !== 1'b0 || r_rdata_o !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL race_c14_resp: rv=%b err=%b rdata=%h want 1 0 0badf00d", r_valid_o, r_err_o, r_rdata_o);
    end
    $display("read  1a1000f4 ready-on-expiry -> rdata=%h err=%b", r_rdata_o, r_err_o);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [4];
    logic [31:0] d_tab [4];
    logic        exp_gnt, exp_rv, exp_psel;
    for (int k = 0; k < 4; k++) begin
      a_tab[k] = 32'h1A10_0100 + 32'(4 * k);
      d_tab[k] = 32'hB0B0_0000 + 32'(k * 32'h11);
    end
    PREADY_i = 1'b1; PSLVERR_i = 1'b0; we_i = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      @(posedge clk_i); #1;
      req_i    = (t <= 9);
      addr_i   = a_tab[(t <= 9) ? (t + 2) / 3 : 3];
      PRDATA_i = d_tab[(t / 3 < 4) ? t / 3 : 3];
      #1;
      exp_gnt  = (t % 3 == 0) && (t < 12);
      exp_rv   = (t % 3 == 0) && (t >= 3);
      exp_psel = (t % 3 != 0);
      vectors++;
      if ({gnt_o, r_valid_o, PSEL_o} !== {exp_gnt, exp_rv, exp_psel}) begin
        miscompares++;
        $display("FAIL b2b_t%0d_ctrl: gnt/rv/psel=%b want %b", t, {gnt_o, r_valid_o, PSEL_o},
                 {exp_gnt, exp_rv, exp_psel});
      end
      if (exp_rv) begin
        vectors++;
        if (r_rdata_o !== d_tab[t / 3 - 1] || r_err_o !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_t%0d_data: rdata=%h err=%b want %h 0", t, r_rdata_o, r_err_o, d_tab[t / 3 - 1]);
        end
        $display("read  %h back-to-back -> rdata=%h", a_tab[t / 3 - 1], r_rdata_o);
      end
    end
    req_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_0200; we_i = 1'b0; PREADY_i = 1'b0; PRDATA_i = 32'h5555_AAAA;
    @(posedge clk_i); #1; req_i = 1'b0;
    @(posedge clk_i); #2;
    vectors++;
    if (PENABLE_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_access: pen=%b want 1", PENABLE_o);
    end
    #1 rst_ni = 1'b0;
    #1;
    vectors++;
    if (PSEL_o !== 1'b0 || PENABLE_o !== 1'b0 || r_valid_o !== 1'b0 || r_rdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_async: psel=%b pen=%b rv=%b rdata=%h want 0 0 0 00000000",
               PSEL_o, PENABLE_o, r_valid_o, r_rdata_o);
    end
    @(posedge clk_i);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    PREADY_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #2;
      vectors++;
      if (r_valid_o !== 1'b0 || PSEL_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_quiet%0d: rv=%b psel=%b want 0 0", c, r_valid_o, PSEL_o);
      end
    end
    $display("reset during ACCESS at 1a100200 -> transfer dropped");
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = 32'h1A10_0204; PRDATA_i = 32'h600D_0001;
    #1;
    vectors++;
    if (gnt_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_regrant: gnt=%b want 1", gnt_o);
    end
    @(posedge clk_i); #1; req_i = 1'b0; #1;
    vectors++;
    if ({PSEL_o, PENABLE_o} !== 2'b10 || PADDR_o !== 32'h1A10_0204) begin
      miscompares++;
      $display("FAIL rstmid_setup: psel/pen=%b paddr=%h want 10 1a100204", {PSEL_o, PENABLE_o}, PADDR_o);
    end
    @(posedge clk_i);
    @(posedge clk_i); #2;
    vectors++;
    if (r_valid_o !== 1'b1 || r_rdata_o !== 32'h600D_0001 || r_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_resp: rv=%b rdata=%h err=%b want 1 600d0001 0", r_valid_o, r_rdata_o, r_err_o);
    end
    $display("read  1a100204 after reset -> rdata=%h err=%b", r_rdata_o, r_err_o);
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_i     = 1'b0;
    addr_i    = 32'h0;
    we_i      = 1'b0;
    wdata_i   = 32'h0;
    PRDATA_i  = 32'h0;
    PREADY_i  = 1'b0;
    PSLVERR_i = 1'b0;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
